wb_commit_stage: RTL
====================

# wb_commit_stage

Parametrised write-back/commit stage for the five-stage MIPS pipeline, replacing the single-register WB stage. Entries from the MEM stage land in a DEPTH-entry in-order retire queue. The head entry commits to a register-file write port that may be shared and stalled (`rf_ready`), drives the CP0 commit interface, and raises a pipeline flush on exception or `eret`. Byte-granular register writes support `lwl`/`lwr` merging, and the forwarding path carries the true write-back data, including `mfc0` results.

## Interface
Parameters:
- DATA_W, 32, datapath width; multiple of 8
- DEPTH, 2, retire-queue entries; power of two, ≥1
- EXCODE_W, 5, exception-code width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ms_to_ws_valid  in  1  MEM entry valid
- ws_allowin  out  1  stage can accept this cycle
- ms_pc  in  32  entry PC
- ms_gr_we  in  DATA_W/8  GPR byte write strobes
- ms_dest  in  5  GPR destination
- ms_result  in  DATA_W  ALU/load result
- ms_res_from_cp0  in  1  `mfc0`: write `cp0_rdata` to GPR
- ms_mtc0  in  1  `mtc0`
- ms_cp0_addr  in  5  CP0 register number
- ms_rt_value  in  DATA_W  `mtc0` data
- ms_ex  in  1  exception flagged upstream
- ms_excode  in  EXCODE_W  exception code
- ms_badvaddr  in  32  faulting address
- ms_bd  in  1  branch-delay-slot flag
- ms_eret  in  1  `eret`
- rf_ready  in  1  RF port grants a write this cycle
- rf_we  out  DATA_W/8  RF byte write enables
- rf_waddr  out  5  RF address
- rf_wdata  out  DATA_W  RF data
- cp0_addr  out  5  CP0 read/write address (head entry)
- cp0_rdata  in  DATA_W  CP0 read data (combinational)
- cp0_mtc0_we  out  1  CP0 write pulse
- cp0_wdata  out  DATA_W  CP0 write data
- cp0_ex  out  1  exception commit pulse
- cp0_excode  out  EXCODE_W  exception code
- cp0_badvaddr  out  32  faulting address
- cp0_bd  out  1  delay-slot flag
- cp0_pc  out  32  committing PC
- cp0_eret  out  1  `eret` commit pulse
- ws_flush  out  1  pipeline flush (exception or `eret` commit)
- fwd_valid  out  1  head entry writes a GPR
- fwd_dest  out  5  head destination
- fwd_data  out  DATA_W  head write data (`rf_wdata` value)
- ws_pending  out  $clog2(DEPTH)+1  occupied entries

## Operation
- **Queue:** circular buffer with `rd_ptr`, `wr_ptr` and `count`.
  - Push when `ms_to_ws_valid && ws_allowin`.
  - The head commits when the queue is non-empty, state is RUN, and either `rf_ready` or the entry needs no GPR write (`ms_gr_we==0`, `ex`, or `eret`).
- **ws_allowin:** `(count<DEPTH || commit) && state==RUN && !ws_flush`.
- **Head data:** `rf_wdata = res_from_cp0 ? cp0_rdata : result`. `cp0_addr` always reflects the head entry. `fwd_data = rf_wdata`. `fwd_valid = non-empty && |gr_we && !ex`.
- **Normal commit:**
  - `rf_we = gr_we` when committing and `!ex && !eret`; else 0.
  - `cp0_mtc0_we = commit && mtc0 && !ex`.
- **Exception or eret commit:**
  - Pulse `cp0_ex` (for `ex`) or `cp0_eret` (for `eret`) together with `ws_flush` for exactly one cycle.
  - `ex` and `eret` both set: `cp0_ex` wins, no `eret`.
  - At the clock edge, the queue empties (`count←0`, `wr_ptr←rd_ptr+1`) and any same-cycle push is dropped.
  - The FSM then moves to FLUSH.
- **FSM:**
  - RUN: normal operation; goes to FLUSH on an `ex`/`eret` commit.
  - FLUSH: `ws_allowin=0`, no commits; returns to RUN after one cycle.
- **Reset (mid-operation included):** state RUN, `count`/pointers 0, all queue contents invalid.
- **Boundary cases:**
  - Full queue with simultaneous push and pop: accepted, `count` unchanged.
  - Pointers wrap modulo DEPTH.
  - Empty queue: no commit, all pulses 0.

## Timing
- Latency: an entry accepted at edge N commits in cycle N+1 if the queue was empty and `rf_ready=1`.
- Throughput: one commit per cycle. With DEPTH=1 full rate is sustained through the same-cycle pop/push path.
- `rf_ready=0` on a GPR-writing head stalls the head. The queue fills, then `ws_allowin` drops in the cycle `count==DEPTH` with no commit.
- Output values after reset, until first commit: `rf_we=0`, `cp0_ex=0`, `cp0_eret=0`, `cp0_mtc0_we=0`, `ws_flush=0`, `fwd_valid=0`, `ws_pending=0`, `ws_allowin=1`. Data outputs are don't-care while the queue is empty.
- `cp0_rdata` is sampled combinationally in the commit cycle. CP0 must present it with zero-cycle latency.

## Configuration
- **WB_TRACE_EN:** when defined, adds these outputs, all driven from the committing head:
  - `debug_wb_pc` [31:0]
  - `debug_wb_rf_wen` [DATA_W/8-1:0] = `rf_we`
  - `debug_wb_rf_wnum` [4:0]
  - `debug_wb_rf_wdata` [DATA_W-1:0] = `rf_wdata`, i.e. CP0 data for `mfc0`.
- When not defined, these ports and their logic do not exist.

## Test plan
- **Basic write:** reset, push `pc=0xBFC00000`, `dest=5`, `result=0x12345678`, `gr_we=4'hF`, `rf_ready=1` -> next cycle `rf_we=F`, `rf_waddr=5`, `rf_wdata=0x12345678`, `fwd_valid=1`.
- **Backpressure:** DEPTH=2, `rf_ready=0`, push 3 back-to-back -> `ws_allowin=0` after 2 accepted. `rf_ready=1` -> entries commit in order, one per cycle, with the third accepted on the first pop.
- **mfc0:** head `res_from_cp0=1`, `cp0_addr=12`, `cp0_rdata=0x0040FF01` -> `rf_wdata` and `fwd_data` both equal `0x0040FF01`.
- **Exception flush:** queue holds an `ex` entry (`excode=0x04`, `badvaddr=0x80000003`) with a younger entry behind it, plus a push in the same cycle -> `cp0_ex=1` and `ws_flush=1` for one cycle, `rf_we=0`. The younger entry and the pushed entry are discarded, `ws_pending=0`, and `ws_allowin=0` for the following cycle.
- **eret and mtc0:** `mtc0` (addr 14, data `0xBFC00380`) followed by `eret` -> `cp0_mtc0_we` pulses, then `cp0_eret` and `ws_flush` pulse on the next commit. An entry with both `ex` and `eret` set -> `cp0_ex` only.
- **Reset while full:** assert `reset` -> the next cycle shows `ws_pending=0`, `ws_allowin=1` and no `rf_we` pulse.

Source files
------------

// File: rtl/wb_commit_if.sv
// ============================================================================
// Module   : wb_commit_if
// Purpose  : MEM->WB entry, register-file, CP0 and forwarding bundle for
//            wb_commit_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_commit_if #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2,
    parameter int EXCODE_W = 5
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                  ms_to_ws_valid;
    logic                  ws_allowin;
    logic [31:0]           ms_pc;
    logic [DATA_W/8-1:0]   ms_gr_we;
    logic [4:0]            ms_dest;
    logic [DATA_W-1:0]     ms_result;
    logic                  ms_res_from_cp0;
    logic                  ms_mtc0;
    logic [4:0]            ms_cp0_addr;
    logic [DATA_W-1:0]     ms_rt_value;
    logic                  ms_ex;
    logic [EXCODE_W-1:0]   ms_excode;
    logic [31:0]           ms_badvaddr;
    logic                  ms_bd;
    logic                  ms_eret;
    logic                  rf_ready;
    logic [DATA_W/8-1:0]   rf_we;
    logic [4:0]            rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [4:0]            cp0_addr;
    logic [DATA_W-1:0]     cp0_rdata;
    logic                  cp0_mtc0_we;
    logic [DATA_W-1:0]     cp0_wdata;
    logic                  cp0_ex;
    logic [EXCODE_W-1:0]   cp0_excode;
    logic [31:0]           cp0_badvaddr;
    logic                  cp0_bd;
    logic [31:0]           cp0_pc;
    logic                  cp0_eret;
    logic                  ws_flush;
    logic                  fwd_valid;
    logic [4:0]            fwd_dest;
    logic [DATA_W-1:0]     fwd_data;
    logic [c_cnt_w-1:0]    ws_pending;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
               ms_res_from_cp0, ms_mtc0, ms_cp0_addr, ms_rt_value, ms_ex,
               ms_excode, ms_badvaddr, ms_bd, ms_eret, rf_ready, cp0_rdata,
        input  ws_allowin, rf_we, rf_waddr, rf_wdata, cp0_addr, cp0_mtc0_we,
               cp0_wdata, cp0_ex, cp0_excode, cp0_badvaddr, cp0_bd, cp0_pc,
               cp0_eret, ws_flush, fwd_valid, fwd_dest, fwd_data, ws_pending
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
               ms_res_from_cp0, ms_mtc0, ms_cp0_addr, ms_rt_value, ms_ex,
               ms_excode, ms_badvaddr, ms_bd, ms_eret, rf_ready, cp0_rdata,
        output ws_allowin, rf_we, rf_waddr, rf_wdata, cp0_addr, cp0_mtc0_we,
               cp0_wdata, cp0_ex, cp0_excode, cp0_badvaddr, cp0_bd, cp0_pc,
               cp0_eret, ws_flush, fwd_valid, fwd_dest, fwd_data, ws_pending
    );
endinterface

`default_nettype wire

// File: rtl/wb_commit_stage.sv
// ============================================================================
// Module   : wb_commit_stage
// Purpose  : In-order retire queue committing to a stallable RF port and CP0;
//            optional commit trace outputs enabled by macro WB_TRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_commit_stage #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2,
    parameter int EXCODE_W = 5
) (
    input  wire         clk,
    input  wire         reset,
    wb_commit_if.slave  bus
`ifdef WB_TRACE_EN
    ,
    output logic [31:0]         debug_wb_pc,
    output logic [DATA_W/8-1:0] debug_wb_rf_wen,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [DATA_W-1:0]   debug_wb_rf_wdata
`endif
);
    localparam int c_nb    = DATA_W / 8;
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0]         pc;
        logic [c_nb-1:0]     gr_we;
        logic [4:0]          dest;
        logic [DATA_W-1:0]   result;
        logic                res_from_cp0;
        logic                mtc0;
        logic [4:0]          cp0_addr;
        logic [DATA_W-1:0]   rt_value;
        logic                ex;
        logic [EXCODE_W-1:0] excode;
        logic [31:0]         badvaddr;
        logic                bd;
        logic                eret;
    } entry_t;

    state_t               r_state;
    entry_t               r_q [DEPTH];
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;

    entry_t               w_head;
    entry_t               w_new;
    logic                 w_nonempty;
    logic                 w_no_rf;
    logic                 w_commit;
    logic                 w_flush;
    logic                 w_allowin;
    logic                 w_push;
    logic [c_nb-1:0]      w_rf_we;
    logic [DATA_W-1:0]    w_rf_wdata;

    function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign w_new = '{pc: bus.ms_pc, gr_we: bus.ms_gr_we, dest: bus.ms_dest,
                     result: bus.ms_result, res_from_cp0: bus.ms_res_from_cp0,
                     mtc0: bus.ms_mtc0, cp0_addr: bus.ms_cp0_addr,
                     rt_value: bus.ms_rt_value, ex: bus.ms_ex,
                     excode: bus.ms_excode, badvaddr: bus.ms_badvaddr,
                     bd: bus.ms_bd, eret: bus.ms_eret};

    assign w_head     = r_q[r_rd_ptr];
    assign w_nonempty = (r_count != '0);
    // Entries that write no GPR (or will trap) retire even while the RF port is busy.
    assign w_no_rf    = ~|w_head.gr_we || w_head.ex || w_head.eret;
    assign w_commit   = w_nonempty && (r_state == S_RUN) && (bus.rf_ready || w_no_rf);
    assign w_flush    = w_commit && (w_head.ex || w_head.eret);
    assign w_allowin  = ((r_count < c_cnt_w'(DEPTH)) || w_commit)
                        && (r_state == S_RUN) && !w_flush;
    assign w_push     = bus.ms_to_ws_valid && w_allowin;
    assign w_rf_we    = (w_commit && !w_head.ex && !w_head.eret) ? w_head.gr_we : '0;
    assign w_rf_wdata = w_head.res_from_cp0 ? bus.cp0_rdata : w_head.result;

    assign bus.ws_allowin   = w_allowin;
    assign bus.rf_we        = w_rf_we;
    assign bus.rf_waddr     = w_head.dest;
    assign bus.rf_wdata     = w_rf_wdata;
    assign bus.cp0_addr     = w_head.cp0_addr;
    assign bus.cp0_mtc0_we  = w_commit && w_head.mtc0 && !w_head.ex;
    assign bus.cp0_wdata    = w_head.rt_value;
    assign bus.cp0_ex       = w_commit && w_head.ex;
    assign bus.cp0_eret     = w_commit && w_head.eret && !w_head.ex;
    assign bus.cp0_excode   = w_head.excode;
    assign bus.cp0_badvaddr = w_head.badvaddr;
    assign bus.cp0_bd       = w_head.bd;
    assign bus.cp0_pc       = w_head.pc;
    assign bus.ws_flush     = w_flush;
    assign bus.fwd_valid    = w_nonempty && |w_head.gr_we && !w_head.ex;
    assign bus.fwd_dest     = w_head.dest;
    assign bus.fwd_data     = w_rf_wdata;
    assign bus.ws_pending   = r_count;

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = w_head.pc;
    assign debug_wb_rf_wen   = w_rf_we;
    assign debug_wb_rf_wnum  = w_head.dest;
    assign debug_wb_rf_wdata = w_rf_wdata;
`endif

    // Payload storage carries no reset: r_count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= (r_state == S_RUN && w_flush) ? S_FLUSH : S_RUN;
            if (w_flush) begin
                // Younger entries are squashed by realigning the write pointer after the trapping head.
                r_count  <= '0;
                r_rd_ptr <= f_next(r_rd_ptr);
                r_wr_ptr <= f_next(r_rd_ptr);
            end else begin
                if (w_push) begin
                    r_wr_ptr <= f_next(r_wr_ptr);
                end
                if (w_commit) begin
                    r_rd_ptr <= f_next(r_rd_ptr);
                end
                r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_commit);
            end
        end
    end
endmodule

`default_nettype wire
